// File: rtl/memotable_pkg.sv
// memotable_pkg: memo entry layout, sizing parameters and apply-sequencer state encoding.
package memotable_pkg;
  localparam int MEMO_MAX_WRITES = 3;
  localparam int XLEN = 32;
  localparam int REGW = 5;
  // One extra code point so idx can step past the top slot without wrapping.
  localparam int IDXW = $clog2(MEMO_MAX_WRITES + 1);
  typedef struct packed {
    logic [MEMO_MAX_WRITES-1:0]           wr_mask;
    logic [MEMO_MAX_WRITES-1:0][REGW-1:0] wr_ids;
    logic [MEMO_MAX_WRITES-1:0][XLEN-1:0] wr_vals;
    logic [XLEN-1:0]                      next_pc;
  } memo_entry_t;
  typedef enum logic [1:0] {IDLE, WRITE, REDIRECT} memo_seq_state_e;
endpackage

// File: rtl/memo_next_idx.sv
// memo_next_idx: find the first set mask bit at or above start_i and whether it is the last one.
module memo_next_idx import memotable_pkg::*; (
  input  logic [MEMO_MAX_WRITES-1:0] mask_i,
  input  logic [IDXW-1:0]            start_i,
  output logic                       found_o,
  output logic [IDXW-1:0]            idx_o,
  output logic                       last_o
);
  logic [IDXW-1:0] sel;
  always_comb begin
    found_o = 1'b0;
    sel = '0;
    last_o = 1'b1;
    for (int i = MEMO_MAX_WRITES - 1; i >= 0; i--)
      if (mask_i[i] && IDXW'(i) >= start_i) begin
        found_o = 1'b1;
        sel = IDXW'(i);
      end
    for (int i = 0; i < MEMO_MAX_WRITES; i++)
      if (mask_i[i] && IDXW'(i) > sel) last_o = 1'b0;
  end
  assign idx_o = sel;
endmodule

// File: rtl/memo_apply_seq.sv
// memo_apply_seq: apply a memo hit as RF writes sharing the core writeback port, then redirect fetch.
module memo_apply_seq import memotable_pkg::*; (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hit_valid_i,
  output logic            hit_ready_o,
  input  memo_entry_t     hit_entry_i,
  input  logic            core_wb_valid_i,
  input  logic [REGW-1:0] core_wb_addr_i,
  input  logic [XLEN-1:0] core_wb_data_i,
  input  logic            flush_i,
  output logic            rf_we_o,
  output logic [REGW-1:0] rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            fetch_stall_o,
  output logic [15:0]     applied_cnt_o
);
  memo_seq_state_e state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d, ni;
  logic            issued_q, issued_d, nf, nl, abort, slot_go, mem_we;
  memo_entry_t     ent_q, ent_d;
  logic [15:0]     cnt_q, cnt_d;
  memo_next_idx u_next (
    .mask_i  (ent_q.wr_mask),
    .start_i (idx_q),
    .found_o (nf),
    .idx_o   (ni),
    .last_o  (nl)
  );
  // A flush may only cancel the application before any memo write reached the RF.
  assign abort   = (state_q == WRITE) && flush_i && !issued_q;
  assign slot_go = (state_q == WRITE) && nf && !abort && !core_wb_valid_i;
  assign mem_we  = slot_go && (ent_q.wr_ids[ni] != '0);
  assign hit_ready_o      = (state_q == IDLE) && !flush_i;
  assign fetch_stall_o    = state_q != IDLE;
  assign redirect_valid_o = state_q == REDIRECT;
  assign redirect_pc_o    = redirect_valid_o ? ent_q.next_pc : '0;
  assign rf_we_o          = core_wb_valid_i || mem_we;
  assign rf_waddr_o       = core_wb_valid_i ? core_wb_addr_i : mem_we ? ent_q.wr_ids[ni] : '0;
  assign rf_wdata_o       = core_wb_valid_i ? core_wb_data_i : mem_we ? ent_q.wr_vals[ni] : '0;
  assign applied_cnt_o    = cnt_q;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    issued_d = issued_q;
    ent_d = ent_q;
    cnt_d = cnt_q;
    if (hit_ready_o && hit_valid_i) begin
      ent_d = hit_entry_i;
      idx_d = '0;
      issued_d = 1'b0;
      state_d = |hit_entry_i.wr_mask ? WRITE : REDIRECT;
    end else if (abort) begin
      state_d = IDLE;
    end else if (state_q == WRITE && !nf) begin
      state_d = REDIRECT;
    end else if (slot_go) begin
      idx_d = ni + 1'b1;
      issued_d = 1'b1;
      state_d = nl ? REDIRECT : WRITE;
    end else if (state_q == REDIRECT) begin
      cnt_d = &cnt_q ? cnt_q : cnt_q + 16'd1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      issued_q <= 1'b0;
      ent_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      issued_q <= issued_d;
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
